// File: rtl/host_cmd_sequencer_if.sv
// host_cmd_sequencer_if
// Groups the signals between the host pipe endpoints, the sequencer and the
// emulator top control ports.
//   in_*            host command word stream (host -> sequencer)
//   out_*           response word stream (sequencer -> host)
//   io_host_steps   configuration register
//   io_used_procs   configuration register
//   io_insns_*      instruction handshake, three 16-bit words
//   io_io_i_*       target input handshake, four 16-bit words
//   io_io_o_*       target output handshake, four 16-bit words
//   busy, err       sequencer status
// slave modport: the sequencer. master modport: the host and emulator side.
interface host_cmd_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_bits;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_bits;
   logic [15:0] io_host_steps;
   logic [5:0]  io_used_procs;
   logic        io_insns_valid;
   logic        io_insns_ready;
   logic [15:0] io_insns_bits_0;
   logic [15:0] io_insns_bits_1;
   logic [15:0] io_insns_bits_2;
   logic        io_io_i_valid;
   logic        io_io_i_ready;
   logic [15:0] io_io_i_bits_0;
   logic [15:0] io_io_i_bits_1;
   logic [15:0] io_io_i_bits_2;
   logic [15:0] io_io_i_bits_3;
   logic        io_io_o_valid;
   logic        io_io_o_ready;
   logic [15:0] io_io_o_bits_0;
   logic [15:0] io_io_o_bits_1;
   logic [15:0] io_io_o_bits_2;
   logic [15:0] io_io_o_bits_3;
   logic        busy;
   logic        err;

   modport slave (
      input  in_valid, in_bits, out_ready, io_insns_ready, io_io_i_ready,
             io_io_o_valid, io_io_o_bits_0, io_io_o_bits_1, io_io_o_bits_2,
             io_io_o_bits_3,
      output in_ready, out_valid, out_bits, io_host_steps, io_used_procs,
             io_insns_valid, io_insns_bits_0, io_insns_bits_1, io_insns_bits_2,
             io_io_i_valid, io_io_i_bits_0, io_io_i_bits_1, io_io_i_bits_2,
             io_io_i_bits_3, io_io_o_ready, busy, err
   );

   modport master (
      output in_valid, in_bits, out_ready, io_insns_ready, io_io_i_ready,
             io_io_o_valid, io_io_o_bits_0, io_io_o_bits_1, io_io_o_bits_2,
             io_io_o_bits_3,
      input  in_ready, out_valid, out_bits, io_host_steps, io_used_procs,
             io_insns_valid, io_insns_bits_0, io_insns_bits_1, io_insns_bits_2,
             io_io_i_valid, io_io_i_bits_0, io_io_i_bits_1, io_io_i_bits_2,
             io_io_i_bits_3, io_io_o_ready, busy, err
   );
endinterface

// File: rtl/host_cmd_sequencer.sv
// host_cmd_sequencer
// Decodes a 16-bit host word stream into emulator control: configuration
// writes, instruction loads and lockstep target cycles (4 words in, 4 out).
// Ports:
//   clock  emulator clock
//   reset  synchronous, active-high
//   bus    host_cmd_sequencer_if.slave (host streams + emulator handshakes)
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for a header word
// ARG        | next word is the host_steps value
// LD_COLLECT | collecting the three words of one instruction
// LD_ISSUE   | instruction presented on insns, waiting for ready
// ST_COLLECT | collecting the four target input words
// ST_ISSUE   | input words presented on io_i, waiting for ready
// ST_WAIT_O  | io_o ready high, waiting for target outputs
// ST_DRAIN   | emitting the four captured output words on out
// STAT_OUT   | emitting the status word on out
module host_cmd_sequencer (
   input logic                  clock,
   input logic                  reset,
   host_cmd_sequencer_if.slave  bus
);

   typedef enum logic [3:0] {
      IDLE, ARG, LD_COLLECT, LD_ISSUE, ST_COLLECT, ST_ISSUE, ST_WAIT_O,
      ST_DRAIN, STAT_OUT
   } state_t;

   localparam logic [3:0] OP_NOP    = 4'h0;
   localparam logic [3:0] OP_STEPS  = 4'h1;
   localparam logic [3:0] OP_PROCS  = 4'h2;
   localparam logic [3:0] OP_LOAD   = 4'h3;
   localparam logic [3:0] OP_STEP   = 4'h4;
   localparam logic [3:0] OP_STATUS = 4'hF;

   state_t      state_q, state_nx;
   logic [1:0]  idx_q;
   logic [11:0] rem_q;
   logic        in_ready_q, out_valid_q, insns_valid_q, io_i_valid_q;
   logic        io_o_ready_q, err_q;
   logic [15:0] out_bits_q, host_steps_q;
   logic [5:0]  used_procs_q;
   logic [15:0] insn_q [3];
   logic [15:0] io_i_q [4];
   logic [15:0] obuf_q [4];

   logic        in_fire, insn_fire, io_i_fire, io_o_fire, out_fire;
   logic        last_cnt, bad_op;
   logic [3:0]  opcode;
   logic [11:0] arg;

   assign in_fire   = bus.in_valid && in_ready_q;
   assign insn_fire = insns_valid_q && bus.io_insns_ready;
   assign io_i_fire = io_i_valid_q && bus.io_io_i_ready;
   assign io_o_fire = bus.io_io_o_valid && io_o_ready_q;
   assign out_fire  = out_valid_q && bus.out_ready;
   assign opcode    = bus.in_bits[15:12];
   assign arg       = bus.in_bits[11:0];
   // Zero counts never leave IDLE, so the counter can only be 1 on its last pass.
   assign last_cnt  = (rem_q == 12'd1);

   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_nx;
   end

   always_comb begin
      state_nx = state_q;
      bad_op   = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_fire) begin
               case (opcode)
                  OP_NOP, OP_PROCS: state_nx = IDLE;
                  OP_STEPS:         state_nx = ARG;
                  OP_LOAD:          if (arg != 12'd0) state_nx = LD_COLLECT;
                  OP_STEP:          if (arg != 12'd0) state_nx = ST_COLLECT;
                  OP_STATUS:        state_nx = STAT_OUT;
                  default:          bad_op = 1'b1;
               endcase
            end
         end
         ARG:        if (in_fire) state_nx = IDLE;
         LD_COLLECT: if (in_fire && idx_q == 2'd2) state_nx = LD_ISSUE;
         LD_ISSUE:   if (insn_fire) state_nx = last_cnt ? IDLE : LD_COLLECT;
         ST_COLLECT: if (in_fire && idx_q == 2'd3) state_nx = ST_ISSUE;
         ST_ISSUE:   if (io_i_fire) state_nx = ST_WAIT_O;
         ST_WAIT_O:  if (io_o_fire) state_nx = ST_DRAIN;
         ST_DRAIN:   if (out_fire && idx_q == 2'd3) state_nx = last_cnt ? IDLE : ST_COLLECT;
         STAT_OUT:   if (out_fire) state_nx = IDLE;
         default:    state_nx = IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state so they line up
   // with the state register and never glitch.
   always_ff @(posedge clock) begin
      if (reset) begin
         in_ready_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         insns_valid_q <= 1'b0;
         io_i_valid_q  <= 1'b0;
         io_o_ready_q  <= 1'b0;
         out_bits_q    <= '0;
         host_steps_q  <= '0;
         used_procs_q  <= '0;
         err_q         <= 1'b0;
         idx_q         <= '0;
         rem_q         <= '0;
         for (int i = 0; i < 3; i++) insn_q[i] <= '0;
         for (int i = 0; i < 4; i++) io_i_q[i] <= '0;
         for (int i = 0; i < 4; i++) obuf_q[i] <= '0;
      end else begin
         in_ready_q    <= (state_nx == IDLE) || (state_nx == ARG) ||
                          (state_nx == LD_COLLECT) || (state_nx == ST_COLLECT);
         out_valid_q   <= (state_nx == ST_DRAIN) || (state_nx == STAT_OUT);
         insns_valid_q <= (state_nx == LD_ISSUE);
         io_i_valid_q  <= (state_nx == ST_ISSUE);
         io_o_ready_q  <= (state_nx == ST_WAIT_O);

         if (state_nx != state_q)
            idx_q <= '0;
         else if ((in_fire && (state_q == LD_COLLECT || state_q == ST_COLLECT)) ||
                  (out_fire && state_q == ST_DRAIN))
            idx_q <= idx_q + 2'd1;

         if (state_q == IDLE && in_fire) begin
            case (opcode)
               OP_PROCS:         used_procs_q <= arg[5:0];
               OP_LOAD, OP_STEP: rem_q <= arg;
               OP_STATUS:        out_bits_q <= {err_q, 3'b000, 6'b000000, used_procs_q};
               default:          ;
            endcase
         end
         if (bad_op) err_q <= 1'b1;

         if (state_q == ARG && in_fire) host_steps_q <= bus.in_bits;

         if (state_q == LD_COLLECT && in_fire) insn_q[idx_q] <= bus.in_bits;
         if (insn_fire) rem_q <= rem_q - 12'd1;

         if (state_q == ST_COLLECT && in_fire) io_i_q[idx_q] <= bus.in_bits;

         if (io_o_fire) begin
            obuf_q[0]  <= bus.io_io_o_bits_0;
            obuf_q[1]  <= bus.io_io_o_bits_1;
            obuf_q[2]  <= bus.io_io_o_bits_2;
            obuf_q[3]  <= bus.io_io_o_bits_3;
            out_bits_q <= bus.io_io_o_bits_0;
         end

         if (state_q == ST_DRAIN && out_fire) begin
            if (idx_q == 2'd3) rem_q <= rem_q - 12'd1;
            else               out_bits_q <= obuf_q[idx_q + 2'd1];
         end
      end
   end

   assign bus.in_ready        = in_ready_q;
   assign bus.out_valid       = out_valid_q;
   assign bus.out_bits        = out_bits_q;
   assign bus.io_host_steps   = host_steps_q;
   assign bus.io_used_procs   = used_procs_q;
   assign bus.io_insns_valid  = insns_valid_q;
   assign bus.io_insns_bits_0 = insn_q[0];
   assign bus.io_insns_bits_1 = insn_q[1];
   assign bus.io_insns_bits_2 = insn_q[2];
   assign bus.io_io_i_valid   = io_i_valid_q;
   assign bus.io_io_i_bits_0  = io_i_q[0];
   assign bus.io_io_i_bits_1  = io_i_q[1];
   assign bus.io_io_i_bits_2  = io_i_q[2];
   assign bus.io_io_i_bits_3  = io_i_q[3];
   assign bus.io_io_o_ready   = io_o_ready_q;
   assign bus.busy            = (state_q != IDLE);
   assign bus.err             = err_q;

endmodule

// File: tb/tb_host_cmd_sequencer.sv
// tb_host_cmd_sequencer
// Directed bench for host_cmd_sequencer. Expected insn, io_i and out words
// are queued when the stimulus is driven and popped by handshake monitors.
module tb_host_cmd_sequencer;
   logic clock = 1'b0;
   logic reset = 1'b1;

   host_cmd_sequencer_if bus();

   host_cmd_sequencer dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int insn_hs  = 0;
   int io_i_hs  = 0;
   int cyc      = 0;

   logic [47:0] exp_insn [$];
   logic [63:0] exp_io_i [$];
   logic [15:0] exp_out  [$];

   logic        resp_mode = 1'b0;
   logic [15:0] o_fixed [4];

   always @(posedge clock) cyc++;

   // Emulator model: either fixed outputs or the bitwise inverse of the inputs.
   always_comb begin
      bus.io_io_o_bits_0 = resp_mode ? ~bus.io_io_i_bits_0 : o_fixed[0];
      bus.io_io_o_bits_1 = resp_mode ? ~bus.io_io_i_bits_1 : o_fixed[1];
      bus.io_io_o_bits_2 = resp_mode ? ~bus.io_io_i_bits_2 : o_fixed[2];
      bus.io_io_o_bits_3 = resp_mode ? ~bus.io_io_i_bits_3 : o_fixed[3];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs are stable from posedge+1 through the next posedge, so a
   // valid/ready pair seen on the falling edge completes on the next rise.
   always @(negedge clock) begin
      if (!reset) begin
         if (bus.io_insns_valid && bus.io_insns_ready) begin
            insn_hs++;
            chk("insn_expected", 64'(exp_insn.size() != 0), 64'd1);
            if (exp_insn.size() != 0)
               chk("insn_bits", 64'({bus.io_insns_bits_0, bus.io_insns_bits_1,
                                     bus.io_insns_bits_2}), 64'(exp_insn.pop_front()));
         end
         if (bus.io_io_i_valid && bus.io_io_i_ready) begin
            io_i_hs++;
            chk("io_i_expected", 64'(exp_io_i.size() != 0), 64'd1);
            if (exp_io_i.size() != 0)
               chk("io_i_bits", {bus.io_io_i_bits_0, bus.io_io_i_bits_1,
                                 bus.io_io_i_bits_2, bus.io_io_i_bits_3},
                   exp_io_i.pop_front());
         end
         if (bus.out_valid && bus.out_ready) begin
            chk("out_expected", 64'(exp_out.size() != 0), 64'd1);
            if (exp_out.size() != 0)
               chk("out_bits", 64'(bus.out_bits), 64'(exp_out.pop_front()));
         end
      end
   end

   task automatic send(input logic [15:0] w);
      int   c = 0;
      logic r;
      bus.in_valid = 1'b1;
      bus.in_bits  = w;
      forever begin
         @(negedge clock);
         r = bus.in_ready;
         @(posedge clock);
         #1;
         if (r) break;
         c++;
         if (c > 200) begin
            chk("in_accept_timeout", 64'(r), 64'd1);
            break;
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int max_cyc);
      int c = 0;
      while ((bus.busy || exp_insn.size() != 0 || exp_io_i.size() != 0 ||
              exp_out.size() != 0) && c < max_cyc) begin
         @(posedge clock);
         #1;
         c++;
      end
      chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
      chk({tag, "_pending"}, 64'(exp_insn.size() + exp_io_i.size() + exp_out.size()), 64'd0);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_ctl"}, 64'({bus.in_ready, bus.out_valid, bus.io_insns_valid,
                              bus.io_io_i_valid, bus.io_io_o_ready, bus.busy, bus.err}), 64'd0);
      chk({tag, "_cfg"}, 64'({bus.io_host_steps, bus.io_used_procs, bus.out_bits}), 64'd0);
      chk({tag, "_insn"}, 64'({bus.io_insns_bits_0, bus.io_insns_bits_1,
                               bus.io_insns_bits_2}), 64'd0);
      chk({tag, "_io_i"}, {bus.io_io_i_bits_0, bus.io_io_i_bits_1,
                           bus.io_io_i_bits_2, bus.io_io_i_bits_3}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int c0;
      bus.in_valid       = 1'b0;
      bus.in_bits        = '0;
      bus.out_ready      = 1'b0;
      bus.io_insns_ready = 1'b0;
      bus.io_io_i_ready  = 1'b0;
      bus.io_io_o_valid  = 1'b0;
      o_fixed[0] = 16'h0; o_fixed[1] = 16'h0; o_fixed[2] = 16'h0; o_fixed[3] = 16'h0;

      repeat (3) @(posedge clock);
      #1;
      check_reset("reset_init");
      reset = 1'b0;

      // SET_PROCS then SET_STEPS
      send(16'h2005);
      send(16'h1000);
      send(16'h0400);
      wait_idle("cfg", 20);
      chk("cfg_used_procs", 64'(bus.io_used_procs), 64'd5);
      chk("cfg_host_steps", 64'(bus.io_host_steps), 64'h0400);

      // LOAD_INSNS 2 with a 5-cycle stall on the first instruction
      bus.io_insns_ready = 1'b0;
      exp_insn.push_back({16'hA001, 16'hA002, 16'hA003});
      exp_insn.push_back({16'hB001, 16'hB002, 16'hB003});
      send(16'h3002);
      send(16'hA001);
      send(16'hA002);
      send(16'hA003);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("ld_stall_valid", 64'(bus.io_insns_valid), 64'd1);
         chk("ld_stall_bits", 64'({bus.io_insns_bits_0, bus.io_insns_bits_1,
                                   bus.io_insns_bits_2}), 64'({16'hA001, 16'hA002, 16'hA003}));
         chk("ld_stall_in_ready", 64'(bus.in_ready), 64'd0);
         @(posedge clock);
         #1;
      end
      bus.io_insns_ready = 1'b1;
      send(16'hB001);
      send(16'hB002);
      send(16'hB003);
      wait_idle("ld", 50);
      chk("ld_insn_count", 64'(insn_hs), 64'd2);

      // STEP 1 with fixed target outputs and out_ready toggling
      bus.io_io_i_ready = 1'b1;
      bus.io_io_o_valid = 1'b1;
      bus.out_ready     = 1'b0;
      o_fixed[0] = 16'h000A; o_fixed[1] = 16'h000B; o_fixed[2] = 16'h000C; o_fixed[3] = 16'h000D;
      exp_io_i.push_back({16'h0011, 16'h0022, 16'h0033, 16'h0044});
      exp_out.push_back(16'h000A);
      exp_out.push_back(16'h000B);
      exp_out.push_back(16'h000C);
      exp_out.push_back(16'h000D);
      send(16'h4001);
      send(16'h0011);
      send(16'h0022);
      send(16'h0033);
      send(16'h0044);
      c = 0;
      while (!bus.out_valid && c < 50) begin
         @(posedge clock);
         #1;
         c++;
      end
      chk("st1_out_valid", 64'(bus.out_valid), 64'd1);
      chk("st1_o_ready_dropped", 64'(bus.io_io_o_ready), 64'd0);
      // Outputs must come from the capture buffer, not the live port.
      o_fixed[0] = 16'hDEAD; o_fixed[1] = 16'hBEEF; o_fixed[2] = 16'hDEAD; o_fixed[3] = 16'hBEEF;
      for (int i = 0; i < 16; i++) begin
         bus.out_ready = (i % 2 == 1);
         @(posedge clock);
         #1;
      end
      bus.out_ready = 1'b1;
      wait_idle("st1", 50);

      // STEP 2, back-to-back drain, outputs are inverted inputs
      resp_mode = 1'b1;
      exp_io_i.push_back({16'h0101, 16'h0202, 16'h0303, 16'h0404});
      exp_io_i.push_back({16'h1111, 16'h2222, 16'h3333, 16'h4444});
      exp_out.push_back(16'hFEFE);
      exp_out.push_back(16'hFDFD);
      exp_out.push_back(16'hFCFC);
      exp_out.push_back(16'hFBFB);
      exp_out.push_back(16'hEEEE);
      exp_out.push_back(16'hDDDD);
      exp_out.push_back(16'hCCCC);
      exp_out.push_back(16'hBBBB);
      send(16'h4002);
      send(16'h0101); send(16'h0202); send(16'h0303); send(16'h0404);
      send(16'h1111); send(16'h2222); send(16'h3333); send(16'h4444);
      wait_idle("st2", 100);
      chk("st_io_i_count", 64'(io_i_hs), 64'd3);

      // Bad opcode, then STATUS
      send(16'h7123);
      chk("bad_err", 64'(bus.err), 64'd1);
      chk("bad_busy", 64'(bus.busy), 64'd0);
      exp_out.push_back(16'h8005);
      send(16'hF000);
      wait_idle("stat", 20);

      // Zero counts: no handshakes, next header taken the following cycle
      send(16'h4000);
      chk("zero_step_in_ready", 64'(bus.in_ready), 64'd1);
      c0 = cyc;
      send(16'h3000);
      chk("zero_back_to_back", 64'(cyc - c0), 64'd1);
      chk("zero_load_in_ready", 64'(bus.in_ready), 64'd1);
      send(16'h2047);
      chk("zero_procs", 64'(bus.io_used_procs), 64'd7);
      chk("zero_no_insn", 64'(insn_hs), 64'd2);
      chk("zero_no_io_i", 64'(io_i_hs), 64'd3);

      // Reset in the middle of a LOAD_INSNS, then a clean load
      bus.io_insns_ready = 1'b0;
      send(16'h3001);
      send(16'h5501);
      send(16'h5502);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check_reset("reset_mid");
      reset = 1'b0;
      bus.io_insns_ready = 1'b1;
      exp_insn.push_back({16'hC001, 16'hC002, 16'hC003});
      send(16'h3001);
      send(16'hC001);
      send(16'hC002);
      send(16'hC003);
      wait_idle("post_reset", 50);
      chk("post_reset_insn_count", 64'(insn_hs), 64'd3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
